bg_parallax_starfield: RTL and testbench
========================================

# bg_parallax_starfield

Procedural multi-layer parallax starfield background generator for the scrolling-background display path. It replaces fixed star coordinate tables with a per-cell hash. It adds N independently scrolling depth layers, frame-synchronous scroll and twinkle state clocked from `clk`, and a registered 3-stage pixel pipeline. Its outputs feed the background mux alongside the other `bg_*` generators.

## Interface
Parameters:
- `H_RES`, 1024: active width in pixels; scroll wrap modulus.
- `V_RES`, 768: active height in pixels.
- `NUM_LAYERS`, 3: depth layers, 1..4; layer k = 0 is farthest.
- `CELL_LOG2`, 4: star cell size is 2^CELL_LOG2 pixels; legal range 2..4.
- `DENSITY`, 3: a cell holds a star when hash[15:12] < DENSITY; legal range 0..16.
- `SPEED_BASE`, 1: layer k advances (k+1)*SPEED_BASE pixels per frame; must be < H_RES/NUM_LAYERS.
- `TWINKLE_SHIFT`, 3: frame-counter bit position of the twinkle phase.

Ports:
- `clk`, input, 1: pixel clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `bg_en`, input, 1: enable. Low freezes scroll and frame state and forces the output black.
- `video_active`, input, 1: the current pixel is in the active area.
- `pix_x`, input, 11: current pixel column.
- `pix_y`, input, 11: current pixel row.
- `vsync`, input, 1: vertical sync, asynchronous to the block's frame logic.
- `R`, output, 2: red, registered.
- `G`, output, 2: green; always equal to `R`.
- `B`, output, 2: blue; always equal to `R`.

## Operation
- **Frame tick**
  - `vsync` passes through a 2-flop synchronizer.
  - Its rising edge on the synchronized signal produces a 1-cycle `frame_tick`.
- **Frame state** (updates only on `frame_tick` with `bg_en`=1)
  - `frame_cnt` is an 8-bit counter that increments and wraps 255→0.
  - `off[k]` is an 11-bit offset per layer: `off[k] += (k+1)*SPEED_BASE`.
  - If the sum is ≥ H_RES, subtract H_RES, so `off[k]` is always in [0, H_RES-1].
- **Stage 1**
  - `sx = pix_x + off[k]`; if the result is ≥ H_RES, subtract H_RES.
  - `cx = sx >> CELL_LOG2`, `cy = pix_y >> CELL_LOG2`.
  - Local coordinates: `lx = sx[CELL_LOG2-1:0]`, `ly = pix_y[CELL_LOG2-1:0]`.
- **Stage 2: hash, 16-bit**
  - `h[k] = (cx*16'd40503) ^ (cy*16'd2999) ^ (k*16'd7919)`.
  - `cx`, `cy` and `k` are zero-extended to 16 bits; each product is truncated to 16 bits.
- **Stage 3: star test for layer k**
  - `hit[k]` requires all of the following:
    - `h[15:12] < DENSITY`;
    - `lx == h[CELL_LOG2-1:0]` and `ly == h[CELL_LOG2+3:4]`;
    - not twinkled out, i.e. `h[11:9] != frame_cnt[TWINKLE_SHIFT+2:TWINKLE_SHIFT]`.
  - Brightness of layer k: `min(k+1, 3)`.
  - Layer priority: the highest k with `hit[k]` wins; with no hit, the level is 0.
- **Output**
  - `R=G=B` = level when the pipelined `video_active` and `bg_en` are both 1; otherwise 2'b00.
- `off[k]` and `frame_cnt` are sampled by stage 1 in the same cycle. An update on `frame_tick` affects only pixels entering stage 1 in later cycles.

## Timing
- Latency: pixel input to `R/G/B` is exactly 3 `clk` cycles. `video_active` is delayed 3 cycles alongside the pixel data.
- Throughput: 1 pixel per clock, with no stalls.
- `frame_tick` fires 3 `clk` cycles after the `vsync` rising edge: 2 synchronizer flops plus the edge register.
- Reset (asynchronous, active low):
  - all pipeline registers, `R/G/B`, `off[k]`, `frame_cnt` and the synchronizer clear to 0;
  - the first valid output can appear 3 cycles after reset release;
  - reset asserted mid-frame clears everything immediately;
  - a `vsync` already high at reset release produces no tick until the next rising edge.
- Wrap-around:
  - `off[k]` wraps exactly: H_RES-1 + 1 → 0;
  - `frame_cnt` wraps 255 → 0.
- `bg_en` falling: the output goes black for pixels entering after the fall, i.e. 3 cycles later. The registered state is held.
- `bg_en` rising: scrolling resumes from the held offsets.

## Test plan
- **Reset**: hold `rst_n`=0 with `video_active`=1 → `R/G/B`=0. After release, `off`=0 and `frame_cnt`=0.
- **Hash and priority**: defaults, frame 0, pixel (15,14) → layer 1 hits (h=0x1EEF, lx=15, ly=14, phase 7≠0) → `R`=2'b10, exactly 3 clocks after the input.
- **Twinkle**:
  - frame 0, pixel (0,0): layer 0 has h=0 and phase 0 matches → `R`=0;
  - after 8 frame ticks: `off[0]`=8 and `frame_cnt[5:3]`=1, so pixel (1016,0) gives `R`=2'b01.
- **Scroll wrap**: 342 `vsync` pulses → `off[0]`=342, `off[1]`=684, `off[2]`=2 (1026−1024).
- **Enable and blanking**:
  - `bg_en`=0 over 5 vsync pulses → offsets unchanged, output 0;
  - `video_active`=0 at a known star pixel → output 0.
- **Sync**: a `vsync` pulse of one `clk` cycle or longer gives exactly one `frame_tick`, 3 cycles after its rising edge.

Source files
------------

// File: rtl/bg_parallax_starfield.sv
// Procedural multi-layer parallax starfield: per-cell hashed stars, per-layer
// horizontal scroll and twinkle, 3-stage registered pixel pipeline.
module bg_parallax_starfield #(
    parameter int H_RES         = 1024,
    parameter int V_RES         = 768,
    parameter int NUM_LAYERS    = 3,
    parameter int CELL_LOG2     = 4,
    parameter int DENSITY       = 3,
    parameter int SPEED_BASE    = 1,
    parameter int TWINKLE_SHIFT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bg_en,
    input  logic        video_active,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    input  logic        vsync,
    output logic [1:0]  R,
    output logic [1:0]  G,
    output logic [1:0]  B
);

    // ---------------- vsync synchronizer and frame tick ----------------
    logic vs_s1, vs_s2, vs_s3;
    logic sync_live, armed, frame_tick;

    // armed only once vsync has been seen low, so a vsync already high at
    // reset release cannot masquerade as a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1      <= 1'b0;
            vs_s2      <= 1'b0;
            vs_s3      <= 1'b0;
            sync_live  <= 1'b0;
            armed      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            vs_s1      <= vsync;
            vs_s2      <= vs_s1;
            vs_s3      <= vs_s2;
            sync_live  <= 1'b1;
            armed      <= armed | (sync_live & ~vs_s1);
            frame_tick <= vs_s2 & ~vs_s3 & armed;
        end
    end

    // ---------------- frame state: frame counter and layer offsets ----------------
    logic [7:0]  frame_cnt;
    logic [10:0] off      [NUM_LAYERS];
    logic [11:0] off_sum  [NUM_LAYERS];
    logic [10:0] off_next [NUM_LAYERS];

    always_comb begin
        for (int k = 0; k < NUM_LAYERS; k++) begin
            // NOTE: every combinational output gets a default first, so no latch is inferred.
            off_sum[k]  = {1'b0, off[k]} + 12'((k + 1) * SPEED_BASE);
            off_next[k] = off_sum[k][10:0];
            if (off_sum[k] >= 12'(H_RES)) begin
                off_next[k] = 11'(off_sum[k] - 12'(H_RES));
            end
        end
    end

    // NOTE: the offset array is a handful of flops, not a RAM, so it is reset like any register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 8'd0;
            for (int k = 0; k < NUM_LAYERS; k++) off[k] <= '0;
        end else if (frame_tick && bg_en) begin
            frame_cnt <= frame_cnt + 8'd1;
            for (int k = 0; k < NUM_LAYERS; k++) off[k] <= off_next[k];
        end
    end

    // ---------------- stage 1: scrolled coordinates ----------------
    logic [11:0]          sx_sum [NUM_LAYERS];
    logic [10:0]          sx     [NUM_LAYERS];
    logic [10:0]          s1_cx  [NUM_LAYERS];
    logic [CELL_LOG2-1:0] s1_lx  [NUM_LAYERS];
    logic [10:0]          s1_cy;
    logic [CELL_LOG2-1:0] s1_ly;
    logic                 s1_act, s1_en;
    logic [2:0]           s1_phase;

    always_comb begin
        for (int k = 0; k < NUM_LAYERS; k++) begin
            sx_sum[k] = {1'b0, pix_x} + {1'b0, off[k]};
            sx[k]     = sx_sum[k][10:0];
            if (sx_sum[k] >= 12'(H_RES)) begin
                sx[k] = 11'(sx_sum[k] - 12'(H_RES));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                s1_cx[k] <= '0;
                s1_lx[k] <= '0;
            end
            s1_cy    <= '0;
            s1_ly    <= '0;
            s1_act   <= 1'b0;
            s1_en    <= 1'b0;
            s1_phase <= '0;
        end else begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                s1_cx[k] <= sx[k] >> CELL_LOG2;
                s1_lx[k] <= sx[k][CELL_LOG2-1:0];
            end
            s1_cy    <= pix_y >> CELL_LOG2;
            s1_ly    <= pix_y[CELL_LOG2-1:0];
            s1_act   <= video_active && (pix_x < 11'(H_RES)) && (pix_y < 11'(V_RES));
            s1_en    <= bg_en;
            s1_phase <= frame_cnt[TWINKLE_SHIFT+2:TWINKLE_SHIFT];
        end
    end

    // ---------------- stage 2: per-layer cell hash ----------------
    logic [15:0]          hash  [NUM_LAYERS];
    logic [15:0]          s2_h  [NUM_LAYERS];
    logic [CELL_LOG2-1:0] s2_lx [NUM_LAYERS];
    logic [CELL_LOG2-1:0] s2_ly;
    logic                 s2_act, s2_en;
    logic [2:0]           s2_phase;

    always_comb begin
        for (int k = 0; k < NUM_LAYERS; k++) begin
            hash[k] = (16'(s1_cx[k]) * 16'd40503)
                    ^ (16'(s1_cy)    * 16'd2999)
                    ^ (16'(k)        * 16'd7919);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                s2_h[k]  <= '0;
                s2_lx[k] <= '0;
            end
            s2_ly    <= '0;
            s2_act   <= 1'b0;
            s2_en    <= 1'b0;
            s2_phase <= '0;
        end else begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                s2_h[k]  <= hash[k];
                s2_lx[k] <= s1_lx[k];
            end
            s2_ly    <= s1_ly;
            s2_act   <= s1_act;
            s2_en    <= s1_en;
            s2_phase <= s1_phase;
        end
    end

    // ---------------- stage 3: star test, priority, output ----------------
    logic [NUM_LAYERS-1:0] hit;
    logic [1:0]            level;
    logic [1:0]            px_level;

    // Ascending scan: a nearer (higher k) layer overwrites a farther one.
    always_comb begin
        level = 2'd0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            hit[k] = ({1'b0, s2_h[k][15:12]} < 5'(DENSITY))
                  && (s2_lx[k] == s2_h[k][CELL_LOG2-1:0])
                  && (s2_ly    == s2_h[k][CELL_LOG2+3:4])
                  && (s2_h[k][11:9] != s2_phase);
            if (hit[k]) level = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) px_level <= 2'd0;
        else        px_level <= (s2_act && s2_en) ? level : 2'd0;
    end

    assign R = px_level;
    assign G = px_level;
    assign B = px_level;

endmodule

// File: tb/tb_bg_parallax_starfield.sv
// Scoreboard bench for bg_parallax_starfield: directed pixels push hand-computed
// levels into a queue; a monitor pops and compares 3 cycles after issue.
module tb_bg_parallax_starfield;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bg_en;
    logic        video_active;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        vsync;
    logic [1:0]  R, G, B;

    bg_parallax_starfield dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bg_en        (bg_en),
        .video_active (video_active),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .vsync        (vsync),
        .R            (R),
        .G            (G),
        .B            (B)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ticks = 0;
    always @(posedge clk) if (dut.frame_tick === 1'b1) ticks++;

    int n_cmp  = 0;
    int n_fail = 0;

    int         due_q  [$];
    logic [1:0] lvl_q  [$];
    string      name_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares the output due on this cycle, decoupled from the driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                int         d;
                logic [1:0] l;
                string      n;
                d = due_q.pop_front();
                l = lvl_q.pop_front();
                n = name_q.pop_front();
                check({n, " R"}, R, l);
                check({n, " G"}, G, l);
                check({n, " B"}, B, l);
            end
        end
    end

    task automatic probe(input int x, input int y, input logic act, input logic en,
                         input logic [1:0] exp, input string name);
        @(negedge clk);
        pix_x        = 11'(x);
        pix_y        = 11'(y);
        video_active = act;
        bg_en        = en;
        due_q.push_back(cyc + 3);
        lvl_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic gap();
        @(negedge clk);
        pix_x        = '0;
        pix_y        = '0;
        video_active = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (due_q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("scoreboard drain", due_q.size(), 0);
    endtask

    task automatic vs_pulse(input int w);
        @(negedge clk);
        vsync = 1'b1;
        repeat (w) @(negedge clk);
        vsync = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0;
        rst_n        = 1'b0;
        bg_en        = 1'b1;
        video_active = 1'b0;
        pix_x        = '0;
        pix_y        = '0;
        vsync        = 1'b0;

        // Reset holds the output black even on a star pixel.
        repeat (2) @(negedge clk);
        probe(15, 14, 1'b1, 1'b1, 2'd0, "reset hold");
        gap();
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Frame 0, offsets 0.
        probe(15, 14, 1'b1, 1'b1, 2'd2, "hash layer1 (15,14)");
        gap();
        probe(0, 0, 1'b1, 1'b1, 2'd0, "twinkle layer0 f0");
        gap();
        probe(32, 11, 1'b1, 1'b1, 2'd0, "twinkle layer2 f0");
        gap();
        drain();

        // One-cycle vsync: tick exactly 3 edges after the rise, for one cycle.
        @(negedge clk);
        vsync = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vsync = 1'b0;
        @(posedge clk); #1;
        check("tick not early", dut.frame_tick, 1'b0);
        @(posedge clk); #1;
        check("tick at +3", dut.frame_tick, 1'b1);
        @(posedge clk); #1;
        check("tick single cycle", dut.frame_tick, 1'b0);
        repeat (4) @(negedge clk);

        t0 = ticks;
        vs_pulse(20);
        check("long pulse one tick", ticks - t0, 1);
        for (int i = 0; i < 6; i++) vs_pulse(1 + i % 3);
        check("tick count 8", ticks, 8);

        probe(1016, 0, 1'b1, 1'b1, 2'd1, "twinkle layer0 f8");
        gap();
        drain();

        // Advance to frame 342: off = 342/684/2, frame_cnt = 86.
        for (int i = 0; i < 334; i++) vs_pulse(1);
        check("tick count 342", ticks, 342);
        probe(355, 14, 1'b1, 1'b1, 2'd2, "wrap layer1 off684");
        gap();
        probe(682, 0, 1'b1, 1'b1, 2'd1, "wrap layer0 off342");
        gap();
        probe(30, 11, 1'b1, 1'b1, 2'd3, "wrap layer2 off2");
        gap();
        drain();

        // bg_en falling mid-stream, back-to-back pixels.
        probe(355, 14, 1'b1, 1'b1, 2'd2, "before bg_en fall");
        probe(30, 11, 1'b1, 1'b0, 2'd0, "bg_en fall black");
        gap();
        drain();
        t0 = ticks;
        for (int i = 0; i < 5; i++) vs_pulse(1);
        check("ticks while disabled", ticks - t0, 5);
        probe(30, 11, 1'b1, 1'b0, 2'd0, "disabled black");
        gap();
        drain();

        // Re-enable: state held, so the same stars reappear.
        probe(355, 14, 1'b1, 1'b1, 2'd2, "resume layer1");
        probe(682, 0, 1'b1, 1'b1, 2'd1, "resume layer0");
        probe(30, 11, 1'b1, 1'b1, 2'd3, "resume layer2");
        probe(30, 11, 1'b0, 1'b1, 2'd0, "video inactive");
        gap();
        drain();

        // Mid-frame asynchronous reset with vsync high across release.
        @(negedge clk);
        pix_x        = 11'd30;
        pix_y        = 11'd11;
        video_active = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("steady star before reset", R, 2'd3);
        #2;
        rst_n = 1'b0;
        vsync = 1'b1;
        #1;
        check("async reset R", R, 2'd0);
        check("async reset G", G, 2'd0);
        video_active = 1'b0;
        repeat (3) @(negedge clk);
        t0 = ticks;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("no tick from vsync high at release", ticks - t0, 0);
        vsync = 1'b0;
        repeat (4) @(negedge clk);

        probe(15, 14, 1'b1, 1'b1, 2'd2, "after reset layer1");
        gap();
        probe(32, 11, 1'b1, 1'b1, 2'd0, "after reset twinkle f0");
        gap();
        drain();

        t0 = ticks;
        vs_pulse(1);
        check("tick after rearm", ticks - t0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
